// File: rtl/calendar_pkg.sv
// Calendar constants, FSM encoding and leap-year rule shared by
// the forward day counter and the day-of-year decoder.
package calendar_pkg;

    localparam logic [3:0] MON_JAN = 4'd0;
    localparam logic [3:0] MON_FEB = 4'd1;
    localparam logic [3:0] MON_MAR = 4'd2;
    localparam logic [3:0] MON_APR = 4'd3;
    localparam logic [3:0] MON_MAY = 4'd4;
    localparam logic [3:0] MON_JUN = 4'd5;
    localparam logic [3:0] MON_JUL = 4'd6;
    localparam logic [3:0] MON_AUG = 4'd7;
    localparam logic [3:0] MON_SEP = 4'd8;
    localparam logic [3:0] MON_OCT = 4'd9;
    localparam logic [3:0] MON_NOV = 4'd10;
    localparam logic [3:0] MON_DEC = 4'd11;

    localparam int YEAR_LEN = 365;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Offset 0 is deliberately not a leap year.
    function automatic logic is_leap(input logic [6:0] yr);
        return (yr != 7'd0) && (yr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/month_days.sv
// Month length lookup, returned as days-1 so it fits 5 bits.
// Shared by the forward counter and the reverse decoder.
module month_days
    import calendar_pkg::*;
(
    input  logic [3:0] mon,
    input  logic       leap,
    output logic [4:0] days
);

    always_comb begin
        days = 5'd30;
        unique case (mon)
            MON_FEB: days = leap ? 5'd28 : 5'd27;
            MON_APR, MON_JUN,
            MON_SEP, MON_NOV: days = 5'd29;
            default: days = 5'd30;
        endcase
    end

endmodule

// File: rtl/doy_to_date.sv
// Sequential day-of-year to month/day decoder; subtracts one
// month length per cycle until the remainder fits.
module doy_to_date
    import calendar_pkg::*;
#(
    parameter int YEAR_W = 7,
    parameter int DOY_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [YEAR_W-1:0] y,
    input  logic [DOY_W-1:0]  doy,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        mon,
    output logic [4:0]        day
);

    state_t           state;
    logic [DOY_W-1:0] rem;
    logic [3:0]       m;
    logic             leap_q;
    logic             leap_in;
    logic [4:0]       md;
    logic [DOY_W-1:0] ylen;
    logic [DOY_W-1:0] len;

    assign leap_in = is_leap(y);
    assign ylen    = DOY_W'(YEAR_LEN) + DOY_W'(leap_in);
    assign len     = DOY_W'(md) + DOY_W'(1);
    assign busy    = (state != S_IDLE);

    month_days u_month_days (
        .mon  (m),
        .leap (leap_q),
        .days (md)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rem    <= '0;
            m      <= '0;
            leap_q <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            mon    <= '0;
            day    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        leap_q <= leap_in;
                        if (doy >= ylen) begin
                            err   <= 1'b1;
                            mon   <= '0;
                            day   <= '0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err   <= 1'b0;
                            rem   <= doy;
                            m     <= '0;
                            state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    // Range check in IDLE bounds m to December.
                    if (rem < len) begin
                        mon   <= m;
                        day   <= rem[4:0];
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        rem <= rem - len;
                        m   <= m + 4'd1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_doy_to_date.sv
// Scoreboard bench for doy_to_date: driver pushes reference results,
// a negedge monitor pops and compares on every done pulse.
module tb_doy_to_date;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] y = '0;
    logic [8:0] doy = '0;
    logic       busy, done, err;
    logic [3:0] mon;
    logic [4:0] day;

    typedef struct {
        int e;
        int mo;
        int dy;
        int c0;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    doy_to_date dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .y     (y),
        .doy   (doy),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .mon   (mon),
        .day   (day)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // Calendar arithmetic straight from month lengths.
    function automatic void ref_model(input int yv, input int dv,
                                      output int e, output int mo,
                                      output int dy);
        int ml[12];
        int leap;
        int r;
        ml = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        leap = (yv != 0 && yv % 4 == 0) ? 1 : 0;
        ml[1] = 28 + leap;
        e = 0;
        mo = 0;
        dy = 0;
        if (dv >= 365 + leap) begin
            e = 1;
        end else begin
            r = dv;
            while (r >= ml[mo]) begin
                r -= ml[mo];
                mo++;
            end
            dy = r;
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t x;
                int lat;
                x = q.pop_front();
                lat = (x.e != 0) ? 1 : x.mo + 2;
                chk("err", int'(err), x.e);
                chk("mon", int'(mon), x.mo);
                chk("day", int'(day), x.dy);
                chk("latency", cyc - x.c0, lat);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            chk("timeout", 1, 0);
            q.delete();
        end
    endtask

    // Presents start for one cycle, then scrambles the inputs.
    task automatic issue(input int yv, input int dv);
        exp_t x;
        wait_idle();
        y = 7'(yv);
        doy = 9'(dv);
        start = 1'b1;
        ref_model(yv, dv, x.e, x.mo, x.dy);
        x.c0 = cyc;
        q.push_back(x);
        @(negedge clk);
        start = 1'b0;
        y = 7'($urandom);
        doy = 9'($urandom);
    endtask

    initial begin
        int ys[9];
        int ds[9];
        int cnt;
        ys = '{0, 0, 4, 5, 4, 5, 5, 17, 0};
        ds = '{0, 59, 59, 59, 365, 364, 365, 511, 364};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_mon", int'(mon), 0);
        chk("rst_day", int'(day), 0);

        foreach (ys[i]) issue(ys[i], ds[i]);
        wait_idle();

        // Second start during scan must be ignored.
        issue(5, 300);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            cnt++;
            start = (cnt == 2) ? 1'b1 : 1'b0;
            if (cnt == 2) doy = 9'd10;
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_span", cnt, 11);
        wait_idle();

        for (int i = 0; i < 200; i++) begin
            int sel;
            int dv;
            sel = $urandom_range(0, 7);
            if (sel < 2) dv = $urandom_range(362, 367);
            else if (sel == 2) dv = $urandom_range(0, 511);
            else dv = $urandom_range(0, 365);
            issue($urandom_range(0, 127), dv);
        end
        wait_idle();

        // Asynchronous reset mid-scan.
        issue(1, 300);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_err", int'(err), 0);
        chk("arst_mon", int'(mon), 0);
        chk("arst_day", int'(day), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(4, 365);
        wait_idle();
        issue(3, 31);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
